// File: rtl/tinyalu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tinyalu_pkg : TinyALU operation codes and arbiter state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b101
   } operation_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RST   = 3'd3,
      RESP  = 3'd4
   } arb_state_t;

   localparam int RST_PULSE_CYCLES = 2;

   // Unassigned codes 110/111 collapse onto no_op.
   function automatic operation_t decode_op(input logic [2:0] code);
      if (code > 3'b101) begin
         return no_op;
      end
      return operation_t'(code);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyalu_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tinyalu_arbiter_if : requester bus plus TinyALU pin bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface tinyalu_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [3*NUM_REQ-1:0] req_op;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [15:0]          rsp_result;
   logic                 rsp_err;
   logic [7:0]           alu_a;
   logic [7:0]           alu_b;
   logic [2:0]           alu_op;
   logic                 alu_start;
   logic                 alu_reset_n;
   logic                 alu_done;
   logic [15:0]          alu_result;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_done, alu_result,
      output req_ready, rsp_valid, rsp_result, rsp_err,
             alu_a, alu_b, alu_op, alu_start, alu_reset_n
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_done, alu_result,
      input  req_ready, rsp_valid, rsp_result, rsp_err,
             alu_a, alu_b, alu_op, alu_start, alu_reset_n
   );
endinterface
`default_nettype wire

// File: rtl/tinyalu_arbiter_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin one-hot grant with a rotating priority pointer
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic [NUM_REQ-1:0] req,
   input  wire logic               advance,
   output logic      [NUM_REQ-1:0] grant
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_win;

   always_comb begin
      int v_idx;
      grant = '0;
      w_win = '0;
      v_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (grant == '0 && req[v_idx]) begin
            grant[v_idx] = 1'b1;
            w_win        = PTR_W'(v_idx);
         end
      end
   end

   // Priority restarts just past the requester that was last served.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/tinyalu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tinyalu_arbiter : shares one TinyALU among NUM_REQ requesters, round-robin.
// Optional watchdog: define TINYALU_ARB_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module tinyalu_arbiter
   import tinyalu_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input wire logic          clk,
   input wire logic          reset,
   tinyalu_arbiter_if.slave  bus
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int RCNT_W = $clog2(RST_PULSE_CYCLES + 1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_live;
   logic [7:0]        r_a;
   logic [7:0]        r_b;
   operation_t        r_op;
   logic [IDX_W-1:0]  r_idx;
   logic [15:0]       r_result;
   logic              r_err;
   logic [RCNT_W-1:0] r_rst_cnt;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_gidx;
   logic               w_hs;
   operation_t         w_req_op;
   logic               w_timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req_valid),
      .advance (w_hs),
      .grant   (w_grant)
   );

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) w_gidx = IDX_W'(i);
      end
   end

   assign w_hs     = (r_state == IDLE) && r_live && (|(w_grant & bus.req_valid));
   assign w_req_op = decode_op(bus.req_op[3*w_gidx +: 3]);

`ifdef TINYALU_ARB_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (reset || w_hs) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == WAIT) && !bus.alu_done &&
                      (r_wait_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int c_unused_timeout = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_next = (w_req_op == rst_op) ? RST : ISSUE;
         ISSUE:   w_next = (r_op == no_op) ? RESP : WAIT;
         WAIT: begin
            if (bus.alu_done)   w_next = RESP;
            else if (w_timeout) w_next = RST;
         end
         RST:     if (r_rst_cnt == RCNT_W'(RST_PULSE_CYCLES)) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_live    <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= no_op;
         r_idx     <= '0;
         r_result  <= '0;
         r_err     <= 1'b0;
         r_rst_cnt <= '0;
      end else begin
         r_live    <= 1'b1;
         r_rst_cnt <= (r_state == RST) ? r_rst_cnt + 1'b1 : '0;
         if (w_hs) begin
            r_a      <= bus.req_a[8*w_gidx +: 8];
            r_b      <= bus.req_b[8*w_gidx +: 8];
            r_op     <= w_req_op;
            r_idx    <= w_gidx;
            r_result <= '0;
            r_err    <= 1'b0;
         end
         if (r_state == WAIT && bus.alu_done) r_result <= bus.alu_result;
         if (w_timeout)                       r_err    <= 1'b1;
      end
   end

   // RST holds reset low for the pulse, then one released cycle before reporting.
   always_comb begin
      bus.req_ready   = '0;
      bus.rsp_valid   = '0;
      bus.rsp_result  = '0;
      bus.rsp_err     = 1'b0;
      bus.alu_a       = r_a;
      bus.alu_b       = r_b;
      bus.alu_op      = r_op;
      bus.alu_start   = 1'b0;
      bus.alu_reset_n = r_live;
      case (r_state)
         IDLE:  if (r_live) bus.req_ready = w_grant;
         ISSUE: bus.alu_start = 1'b1;
         WAIT:  bus.alu_start = 1'b1;
         RST:   bus.alu_reset_n = (r_rst_cnt >= RCNT_W'(RST_PULSE_CYCLES));
         RESP: begin
            bus.rsp_valid[r_idx] = 1'b1;
            bus.rsp_result       = r_result;
            bus.rsp_err          = r_err;
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_tinyalu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tinyalu_arbiter : scoreboard bench with a behavioural TinyALU model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tinyalu_arbiter;
   import tinyalu_pkg::*;

   localparam int NR  = 2;
   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tinyalu_arbiter_if #(.NUM_REQ(NR)) bus ();

   tinyalu_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b001:  return {8'h00, a} + {8'h00, b};
         3'b010:  return {8'h00, a & b};
         3'b011:  return {8'h00, a ^ b};
         3'b100:  return {8'h00, a} * {8'h00, b};
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op);
      case (op)
         3'b000, 3'b110, 3'b111: return 2;
         3'b101:                 return 4;
         3'b100:                 return 5;
         default:                return 3;
      endcase
   endfunction

   function automatic logic [NR-1:0] rr_expect(input logic [NR-1:0] v, input int last);
      logic [NR-1:0] g;
      g = '0;
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (last + k) % NR;
         if (v[i]) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   // TinyALU model: done one cycle after start, three for mul; never when hung.
   logic        m_done = 1'b0;
   logic [15:0] m_res  = '0;
   logic [7:0]  m_cnt  = '0;
   logic        m_hang;
   assign bus.alu_done   = m_done;
   assign bus.alu_result = m_res;

   always @(posedge clk) begin
      if (bus.alu_reset_n !== 1'b1) begin
         m_cnt  <= '0;
         m_done <= 1'b0;
      end else if (bus.alu_start) begin
         m_cnt <= m_cnt + 8'd1;
         if (!m_hang && (m_cnt + 8'd1) == ((bus.alu_op == 3'b100) ? 8'd3 : 8'd1)) begin
            m_done <= 1'b1;
            m_res  <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
         end else begin
            m_done <= 1'b0;
         end
      end else begin
         m_cnt  <= '0;
         m_done <= 1'b0;
      end
   end

   typedef struct {
      int          idx;
      logic [15:0] res;
      logic        err;
      int          lat;
      int          t;
   } exp_t;

   exp_t sb[$];
   int   cyc        = 0;
   int   last_g     = NR - 1;
   int   low_run    = 0;
   logic boot       = 1'b1;
   logic seen_start = 1'b0;
   logic prev_start = 1'b0;
   int   gap        = 0;

   always @(negedge clk) begin
      exp_t          e;
      int            gi;
      logic [2:0]    op;
      logic [7:0]    a;
      logic [7:0]    b;
      logic [NR-1:0] oh;
      cyc++;
      if (reset) begin
         sb.delete();
         last_g     = NR - 1;
         low_run    = 0;
         boot       = 1'b1;
         seen_start = 1'b0;
         prev_start = 1'b0;
         gap        = 0;
      end else begin
         if (sb.size() != 0) check_val("ready_busy", 32'(bus.req_ready), 32'd0);
         if (bus.req_ready != '0) begin
            check_val("rr_grant", 32'(bus.req_ready), 32'(rr_expect(bus.req_valid, last_g)));
            gi = 0;
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gi = i;
            last_g = gi;
            op = bus.req_op[3*gi +: 3];
            a  = bus.req_a[8*gi +: 8];
            b  = bus.req_b[8*gi +: 8];
            e.idx = gi;
            e.t   = cyc;
            if (m_hang) begin
               e.res = 16'h0000;
               e.err = 1'b1;
               e.lat = TMO + 5;
            end else begin
               e.res = alu_calc(op, a, b);
               e.err = 1'b0;
               e.lat = exp_lat(op);
            end
            sb.push_back(e);
         end
         if (bus.rsp_valid != '0) begin
            if (sb.size() == 0) begin
               check_val("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
               e  = sb.pop_front();
               oh = '0;
               oh[e.idx] = 1'b1;
               check_val("rsp_owner",   32'(bus.rsp_valid),  32'(oh));
               check_val("rsp_result",  32'(bus.rsp_result), 32'(e.res));
               check_val("rsp_err",     32'(bus.rsp_err),    32'(e.err));
               check_val("rsp_latency", 32'(cyc - e.t),      32'(e.lat));
            end
         end
         if (bus.alu_start && !prev_start) begin
            if (seen_start) check_val("start_gap", 32'(gap >= 2), 32'd1);
            seen_start = 1'b1;
         end
         gap        = bus.alu_start ? 0 : gap + 1;
         prev_start = bus.alu_start;
         if (boot) begin
            if (bus.alu_reset_n) boot = 1'b0;
         end else if (!bus.alu_reset_n) begin
            low_run++;
            check_val("rst_start_low", 32'(bus.alu_start), 32'd0);
         end else if (low_run != 0) begin
            check_val("rst_pulse_len", 32'(low_run), 32'd2);
            low_run = 0;
         end
      end
   end

   task automatic check_reset_outputs(input string p);
      check_val({p, "_req_ready"},   32'(bus.req_ready),   32'd0);
      check_val({p, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
      check_val({p, "_rsp_result"},  32'(bus.rsp_result),  32'd0);
      check_val({p, "_rsp_err"},     32'(bus.rsp_err),     32'd0);
      check_val({p, "_alu_a"},       32'(bus.alu_a),       32'd0);
      check_val({p, "_alu_b"},       32'(bus.alu_b),       32'd0);
      check_val({p, "_alu_op"},      32'(bus.alu_op),      32'd0);
      check_val({p, "_alu_start"},   32'(bus.alu_start),   32'd0);
      check_val({p, "_alu_reset_n"}, 32'(bus.alu_reset_n), 32'd0);
   endtask

   task automatic load_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.req_a[8*idx +: 8]  = a;
      bus.req_b[8*idx +: 8]  = b;
      bus.req_op[3*idx +: 3] = op;
   endtask

   task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      load_req(idx, a, b, op);
      bus.req_valid[idx] = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.req_ready[idx]) begin
            got = 1'b1;
            break;
         end
      end
      check_val("handshake_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      bus.req_valid[idx] = 1'b0;
   endtask

   task automatic drain(input int budget);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check_val("drain_done", 32'(ok), 32'd1);
   endtask

   function automatic logic [2:0] cont_op(input int k);
      case (k)
         0:       return 3'b001;
         1:       return 3'b010;
         2:       return 3'b011;
         default: return 3'b100;
      endcase
   endfunction

   int n_served [NR];
   int served;
   int w;

   initial begin
      m_hang        = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("boot_rstn_low", 32'(bus.alu_reset_n), 32'd0);
      @(negedge clk);
      check_val("boot_rstn_high", 32'(bus.alu_reset_n), 32'd1);

      issue(0, 8'h12, 8'h34, 3'b001); drain(20);
      issue(1, 8'hFF, 8'hFF, 3'b100); drain(20);
      issue(0, 8'hA5, 8'h3C, 3'b010); drain(20);
      issue(1, 8'hA5, 8'h3C, 3'b011); drain(20);
      issue(0, 8'h77, 8'h11, 3'b000); drain(20);
      issue(1, 8'h77, 8'h11, 3'b110); drain(20);
      issue(1, 8'h55, 8'h66, 3'b101); drain(20);

      // Both requesters hold valid for four operations each.
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
         n_served[i] = 0;
         load_req(i, 8'(8'h10 + i), 8'(8'h21 + 3*i), cont_op(0));
      end
      bus.req_valid = '1;
      served = 0;
      for (int c = 0; c < 400 && served < 2*4; c++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            w = bus.req_ready[1] ? 1 : 0;
            check_val("cont_order", 32'(w), 32'(served % 2));
            served++;
            n_served[w]++;
            @(posedge clk); #1;
            if (n_served[w] == 4) bus.req_valid[w] = 1'b0;
            else load_req(w, 8'(8'h10 + 16*n_served[w] + w), 8'(37*n_served[w] + 5), cont_op(n_served[w]));
         end
      end
      bus.req_valid = '0;
      check_val("cont_served", 32'(served), 32'd8);
      drain(20);

      // Reset while a mul sits in WAIT: abort with no response.
      issue(1, 8'hC3, 8'h5A, 3'b100);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("midop");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      issue(0, 8'h21, 8'h43, 3'b001); drain(20);

`ifdef TINYALU_ARB_TIMEOUT_EN
      m_hang = 1'b1;
      issue(0, 8'h07, 8'h09, 3'b001);
      drain(60);
      m_hang = 1'b0;
      issue(1, 8'h02, 8'h03, 3'b100); drain(20);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
